// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, result broadcast, operand query, commit and flush signals of the reorder buffer
interface reorder_buffer_if #(parameter int TAG_W = 4);
  logic             rdy;
  logic             in_dispatch_valid;
  logic [4:0]       in_dispatch_dest_reg;
  logic             in_dispatch_is_branch;
  logic             in_dispatch_pred_taken;
  logic [31:0]      in_dispatch_pc;
  logic [TAG_W-1:0] out_dispatch_tag;
  logic             out_full;
  logic             in_cdb_valid;
  logic [TAG_W-1:0] in_cdb_tag;
  logic [31:0]      in_cdb_value;
  logic             in_cdb_taken;
  logic [31:0]      in_cdb_target;
  logic [TAG_W-1:0] in_query_tag1;
  logic [TAG_W-1:0] in_query_tag2;
  logic             out_query_ready1;
  logic             out_query_ready2;
  logic [31:0]      out_query_value1;
  logic [31:0]      out_query_value2;
  logic             out_commit_valid;
  logic [4:0]       out_commit_reg;
  logic [TAG_W-1:0] out_commit_rob;
  logic [31:0]      out_commit_value;
  logic             out_flush;
  logic [31:0]      out_flush_pc;
  modport master (
    output rdy, in_dispatch_valid, in_dispatch_dest_reg, in_dispatch_is_branch, in_dispatch_pred_taken,
           in_dispatch_pc, in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
           in_query_tag1, in_query_tag2,
    input  out_dispatch_tag, out_full, out_query_ready1, out_query_ready2, out_query_value1,
           out_query_value2, out_commit_valid, out_commit_reg, out_commit_rob, out_commit_value,
           out_flush, out_flush_pc
  );
  modport slave (
    input  rdy, in_dispatch_valid, in_dispatch_dest_reg, in_dispatch_is_branch, in_dispatch_pred_taken,
           in_dispatch_pc, in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_taken, in_cdb_target,
           in_query_tag1, in_query_tag2,
    output out_dispatch_tag, out_full, out_query_ready1, out_query_ready2, out_query_value1,
           out_query_value2, out_commit_valid, out_commit_reg, out_commit_rob, out_commit_value,
           out_flush, out_flush_pc
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement queue with CDB completion, operand forwarding and branch misprediction flush
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W = 4
) (
  input logic clk,
  input logic rst,
  reorder_buffer_if.slave rob
);
  logic [TAG_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]   count_q, count_d;
  logic [ROB_DEPTH-1:0] ready_q, ready_d;
  logic [4:0]  dest_q   [ROB_DEPTH];
  logic        branch_q [ROB_DEPTH];
  logic        pred_q   [ROB_DEPTH];
  logic        taken_q  [ROB_DEPTH];
  logic [31:0] pc_q     [ROB_DEPTH];
  logic [31:0] value_q  [ROB_DEPTH];
  logic [31:0] target_q [ROB_DEPTH];
  logic             commit_valid_q, flush_q;
  logic [4:0]       commit_reg_q;
  logic [TAG_W-1:0] commit_rob_q;
  logic [31:0]      commit_value_q, flush_pc_q;
  logic full, flush, disp, commit, cdb_hit, mispredict;
  logic [TAG_W-1:0] cdb_off;
  assign full = count_q == (TAG_W+1)'(ROB_DEPTH);
  assign flush = flush_q & rob.rdy;
  assign disp = rob.in_dispatch_valid & ~full & rob.rdy & ~flush;
  assign commit = rob.rdy & ~flush & (count_q != '0) & ready_q[head_q];
  assign cdb_off = rob.in_cdb_tag - head_q;
  assign cdb_hit = rob.rdy & ~flush & rob.in_cdb_valid & ({1'b0, cdb_off} < count_q) & ~ready_q[rob.in_cdb_tag];
  assign mispredict = branch_q[head_q] & (taken_q[head_q] != pred_q[head_q]);
  always_comb begin
    ready_d = ready_q;
    if (disp) ready_d[tail_q] = 1'b0;
    if (cdb_hit) ready_d[rob.in_cdb_tag] = 1'b1;
    if (flush) ready_d = '0;
    head_d = flush ? '0 : head_q + TAG_W'(commit);
    tail_d = flush ? '0 : tail_q + TAG_W'(disp);
    count_d = flush ? '0 : count_q + (TAG_W+1)'(disp) - (TAG_W+1)'(commit);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      ready_q <= '0;
      commit_valid_q <= 1'b0;
      flush_q <= 1'b0;
      commit_reg_q <= '0;
      commit_rob_q <= '0;
      commit_value_q <= '0;
      flush_pc_q <= '0;
    end else if (rob.rdy) begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      ready_q <= ready_d;
      commit_valid_q <= commit;
      flush_q <= commit & mispredict;
      if (commit) begin
        commit_reg_q <= dest_q[head_q];
        commit_rob_q <= head_q;
        commit_value_q <= value_q[head_q];
      end
      if (commit & mispredict)
        flush_pc_q <= taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && disp) begin
      dest_q[tail_q] <= rob.in_dispatch_dest_reg;
      branch_q[tail_q] <= rob.in_dispatch_is_branch;
      pred_q[tail_q] <= rob.in_dispatch_pred_taken;
      pc_q[tail_q] <= rob.in_dispatch_pc;
    end
    if (!rst && cdb_hit) begin
      value_q[rob.in_cdb_tag] <= rob.in_cdb_value;
      taken_q[rob.in_cdb_tag] <= rob.in_cdb_taken;
      target_q[rob.in_cdb_tag] <= rob.in_cdb_target;
    end
  end
  assign rob.out_dispatch_tag = tail_q;
  assign rob.out_full = full;
  assign rob.out_query_ready1 = (rob.in_cdb_valid && rob.in_cdb_tag == rob.in_query_tag1) ? 1'b1 : ready_q[rob.in_query_tag1];
  assign rob.out_query_ready2 = (rob.in_cdb_valid && rob.in_cdb_tag == rob.in_query_tag2) ? 1'b1 : ready_q[rob.in_query_tag2];
  assign rob.out_query_value1 = (rob.in_cdb_valid && rob.in_cdb_tag == rob.in_query_tag1) ? rob.in_cdb_value : value_q[rob.in_query_tag1];
  assign rob.out_query_value2 = (rob.in_cdb_valid && rob.in_cdb_tag == rob.in_query_tag2) ? rob.in_cdb_value : value_q[rob.in_query_tag2];
  assign rob.out_commit_valid = commit_valid_q & rob.rdy;
  assign rob.out_commit_reg = commit_reg_q;
  assign rob.out_commit_rob = commit_rob_q;
  assign rob.out_commit_value = commit_value_q;
  assign rob.out_flush = flush;
  assign rob.out_flush_pc = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vectors with hand-computed expectations for the reorder buffer
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  reorder_buffer_if #(.TAG_W(4)) bus();
  reorder_buffer #(.ROB_DEPTH(16), .TAG_W(4)) dut (.clk(clk), .rst(rst), .rob(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic do_disp(input logic [4:0] d, input logic br, input logic pr, input logic [31:0] pc);
    bus.in_dispatch_valid = 1'b1;
    bus.in_dispatch_dest_reg = d;
    bus.in_dispatch_is_branch = br;
    bus.in_dispatch_pred_taken = pr;
    bus.in_dispatch_pc = pc;
    tick();
    bus.in_dispatch_valid = 1'b0;
  endtask
  task automatic do_cdb(input logic [3:0] t, input logic [31:0] v, input logic tk, input logic [31:0] tg);
    bus.in_cdb_valid = 1'b1;
    bus.in_cdb_tag = t;
    bus.in_cdb_value = v;
    bus.in_cdb_taken = tk;
    bus.in_cdb_target = tg;
    tick();
    bus.in_cdb_valid = 1'b0;
  endtask
  initial begin
    bus.rdy = 1'b1;
    bus.in_dispatch_valid = 1'b0;
    bus.in_dispatch_dest_reg = '0;
    bus.in_dispatch_is_branch = 1'b0;
    bus.in_dispatch_pred_taken = 1'b0;
    bus.in_dispatch_pc = '0;
    bus.in_cdb_valid = 1'b0;
    bus.in_cdb_tag = '0;
    bus.in_cdb_value = '0;
    bus.in_cdb_taken = 1'b0;
    bus.in_cdb_target = '0;
    bus.in_query_tag1 = '0;
    bus.in_query_tag2 = '0;
    do_reset();
    chk("rst_full", bus.out_full, 0);
    chk("rst_tag", bus.out_dispatch_tag, 0);
    chk("rst_cvalid", bus.out_commit_valid, 0);
    chk("rst_creg", bus.out_commit_reg, 0);
    chk("rst_crob", bus.out_commit_rob, 0);
    chk("rst_cval", bus.out_commit_value, 0);
    chk("rst_flush", bus.out_flush, 0);
    chk("rst_fpc", bus.out_flush_pc, 0);
    chk("rst_qready", bus.out_query_ready1, 0);
    // single dispatch, completion, commit
    do_disp(5'd5, 0, 0, 32'h0);
    chk("d1_tag", bus.out_dispatch_tag, 1);
    do_cdb(4'd0, 32'h1234, 0, 0);
    chk("d1_no_early_commit", bus.out_commit_valid, 0);
    tick();
    chk("d1_cvalid", bus.out_commit_valid, 1);
    chk("d1_creg", bus.out_commit_reg, 5);
    chk("d1_crob", bus.out_commit_rob, 0);
    chk("d1_cval", bus.out_commit_value, 32'h1234);
    tick();
    chk("d1_cvalid_drop", bus.out_commit_valid, 0);
    chk("d1_full", bus.out_full, 0);
    // combinational forwarding and unallocated CDB
    bus.in_query_tag1 = 4'd3;
    bus.in_query_tag2 = 4'd2;
    bus.in_cdb_valid = 1'b1;
    bus.in_cdb_tag = 4'd3;
    bus.in_cdb_value = 32'hAA;
    #1;
    chk("q_fwd_ready", bus.out_query_ready1, 1);
    chk("q_fwd_value", bus.out_query_value1, 32'hAA);
    chk("q_other_ready", bus.out_query_ready2, 0);
    tick();
    bus.in_cdb_valid = 1'b0;
    #1;
    chk("q_unalloc_ignored", bus.out_query_ready1, 0);
    tick();
    chk("q_no_commit", bus.out_commit_valid, 0);
    // fill to capacity, refuse, wrap
    do_reset();
    for (int i = 0; i < 16; i++) do_disp(5'(i + 1), 0, 0, 32'(i * 4));
    chk("fill_full", bus.out_full, 1);
    chk("fill_tag", bus.out_dispatch_tag, 0);
    do_disp(5'd20, 0, 0, 32'h0);
    chk("fill_refused_full", bus.out_full, 1);
    chk("fill_refused_tag", bus.out_dispatch_tag, 0);
    do_cdb(4'd0, 32'h77, 0, 0);
    do_disp(5'd21, 0, 0, 32'h0);
    chk("fill_cvalid", bus.out_commit_valid, 1);
    chk("fill_creg", bus.out_commit_reg, 1);
    chk("fill_cval", bus.out_commit_value, 32'h77);
    chk("fill_notfull", bus.out_full, 0);
    chk("fill_wrap_tag", bus.out_dispatch_tag, 0);
    do_disp(5'd22, 0, 0, 32'h0);
    chk("fill_refull", bus.out_full, 1);
    chk("fill_tag_after", bus.out_dispatch_tag, 1);
    // out-of-order completion, in-order retirement
    do_reset();
    do_disp(5'd1, 0, 0, 0);
    do_disp(5'd2, 0, 0, 4);
    do_disp(5'd3, 0, 0, 8);
    do_cdb(4'd2, 32'h22, 0, 0);
    chk("ooo_wait2", bus.out_commit_valid, 0);
    do_cdb(4'd1, 32'h11, 0, 0);
    chk("ooo_wait1", bus.out_commit_valid, 0);
    do_cdb(4'd0, 32'h10, 0, 0);
    chk("ooo_wait0", bus.out_commit_valid, 0);
    tick();
    chk("ooo_c0_valid", bus.out_commit_valid, 1);
    chk("ooo_c0_rob", bus.out_commit_rob, 0);
    chk("ooo_c0_val", bus.out_commit_value, 32'h10);
    tick();
    chk("ooo_c1_valid", bus.out_commit_valid, 1);
    chk("ooo_c1_rob", bus.out_commit_rob, 1);
    chk("ooo_c1_val", bus.out_commit_value, 32'h11);
    tick();
    chk("ooo_c2_valid", bus.out_commit_valid, 1);
    chk("ooo_c2_rob", bus.out_commit_rob, 2);
    chk("ooo_c2_reg", bus.out_commit_reg, 3);
    chk("ooo_c2_val", bus.out_commit_value, 32'h22);
    tick();
    chk("ooo_done", bus.out_commit_valid, 0);
    // mispredicted taken branch with younger entries
    do_reset();
    do_disp(5'd0, 1, 0, 32'h100);
    do_disp(5'd7, 0, 0, 32'h104);
    do_disp(5'd8, 0, 0, 32'h108);
    do_cdb(4'd1, 32'h1, 0, 0);
    do_cdb(4'd2, 32'h2, 0, 0);
    do_cdb(4'd0, 32'h0, 1, 32'h200);
    chk("br_noflush_yet", bus.out_flush, 0);
    tick();
    chk("br_flush", bus.out_flush, 1);
    chk("br_flush_pc", bus.out_flush_pc, 32'h200);
    chk("br_cvalid", bus.out_commit_valid, 1);
    chk("br_creg_x0", bus.out_commit_reg, 0);
    chk("br_crob", bus.out_commit_rob, 0);
    do_disp(5'd9, 0, 0, 32'h300);
    chk("br_flush_drop", bus.out_flush, 0);
    chk("br_no_young_commit", bus.out_commit_valid, 0);
    chk("br_tag_cleared", bus.out_dispatch_tag, 0);
    bus.in_query_tag1 = 4'd1;
    #1;
    chk("br_ready_cleared", bus.out_query_ready1, 0);
    tick();
    tick();
    chk("br_still_no_commit", bus.out_commit_valid, 0);
    // not-taken mispredict with PC wrap
    do_reset();
    do_disp(5'd2, 1, 1, 32'hFFFF_FFFC);
    do_cdb(4'd0, 32'h0, 0, 32'h500);
    tick();
    chk("nt_flush", bus.out_flush, 1);
    chk("nt_flush_pc_wrap", bus.out_flush_pc, 32'h0);
    tick();
    // correctly predicted branch
    do_reset();
    do_disp(5'd3, 1, 1, 32'h40);
    do_cdb(4'd0, 32'h9, 1, 32'h80);
    tick();
    chk("ok_br_commit", bus.out_commit_valid, 1);
    chk("ok_br_noflush", bus.out_flush, 0);
    // rdy freeze
    do_reset();
    do_disp(5'd4, 0, 0, 0);
    do_cdb(4'd0, 32'h40, 0, 0);
    bus.rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_no_commit", bus.out_commit_valid, 0);
      chk("frz_tag_hold", bus.out_dispatch_tag, 1);
    end
    bus.rdy = 1'b1;
    tick();
    chk("frz_commit", bus.out_commit_valid, 1);
    chk("frz_cval", bus.out_commit_value, 32'h40);
    // reset while a commit is pending
    do_reset();
    do_disp(5'd6, 0, 0, 0);
    do_cdb(4'd0, 32'h66, 0, 0);
    rst = 1'b1;
    tick();
    chk("mrst_no_commit", bus.out_commit_valid, 0);
    chk("mrst_no_flush", bus.out_flush, 0);
    chk("mrst_tag", bus.out_dispatch_tag, 0);
    rst = 1'b0;
    tick();
    chk("mrst_still_none", bus.out_commit_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
